// File: rtl/tsi_pkg.sv
// Shared TSI channel constants, command encodings and arbiter state type.
package tsi_pkg;

    localparam int unsigned TSI_W       = 32;
    localparam int unsigned HDR_WORDS   = 5;
    localparam int unsigned HDR_LEN_LO  = 3;

    localparam logic [TSI_W-1:0] TSI_CMD_READ  = 32'd0;
    localparam logic [TSI_W-1:0] TSI_CMD_WRITE = 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA
    } tsi_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr_i+1 with wrap-around.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    logic           found;
    logic [IDW-1:0] cidx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cidx  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cidx = IDW'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[cidx]) begin
                found       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/tsi_link_arbiter.sv
// Shares one TSI target channel among NREQ requesters, switching owner only at
// packet boundaries and steering read responses back to the issuing requester.
module tsi_link_arbiter
    import tsi_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       host_req_valid,
    output logic [NREQ-1:0]       host_req_ready,
    input  logic [NREQ*TSI_W-1:0] host_req_bits,
    output logic [NREQ-1:0]       host_resp_valid,
    input  logic [NREQ-1:0]       host_resp_ready,
    output logic [NREQ*TSI_W-1:0] host_resp_bits,
    output logic                  tgt_req_valid,
    input  logic                  tgt_req_ready,
    output logic [TSI_W-1:0]      tgt_req_bits,
    input  logic                  tgt_resp_valid,
    output logic                  tgt_resp_ready,
    input  logic [TSI_W-1:0]      tgt_resp_bits,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    output logic                  err
);

    tsi_state_e       state_q;
    logic [IDW-1:0]   owner_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [2:0]       hdr_cnt_q;
    logic [TSI_W-1:0] data_cnt_q;
    logic [TSI_W-1:0] cmd_q;
    logic             err_q;

    logic [NREQ-1:0]  grant_vec;
    logic [IDW-1:0]   grant_idx;
    logic [TSI_W-1:0] req_word [NREQ];
    logic             req_xfer;
    logic             resp_xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i (host_req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (grant_vec),
        .idx_o (grant_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_word[i] = host_req_bits[i*TSI_W +: TSI_W];
        end
    end

    always_comb begin
        tgt_req_valid   = 1'b0;
        tgt_req_bits    = req_word[owner_q];
        host_req_ready  = '0;
        tgt_resp_ready  = 1'b0;
        host_resp_valid = '0;
        host_resp_bits  = {NREQ{tgt_resp_bits}};
        case (state_q)
            HDR, WDATA: begin
                tgt_req_valid           = host_req_valid[owner_q];
                host_req_ready[owner_q] = tgt_req_ready;
            end
            RDATA: begin
                tgt_resp_ready           = host_resp_ready[owner_q];
                host_resp_valid[owner_q] = tgt_resp_valid;
            end
            default: ;
        endcase
    end

    assign req_xfer  = tgt_req_valid && tgt_req_ready;
    assign resp_xfer = tgt_resp_valid && tgt_resp_ready;

    // data_cnt holds len_lo and the beat taken at zero is the last, so 2^32 beats fit in 32 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= IDW'(NREQ - 1);
            hdr_cnt_q  <= '0;
            data_cnt_q <= '0;
            cmd_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant_vec) begin
                        owner_q  <= grant_idx;
                        rr_ptr_q <= grant_idx;
                        state_q  <= HDR;
                    end
                end
                HDR: begin
                    if (req_xfer) begin
                        if (hdr_cnt_q == 3'd0) begin
                            cmd_q <= tgt_req_bits;
                            if (tgt_req_bits > TSI_CMD_WRITE) begin
                                err_q <= 1'b1;
                            end
                        end
                        if (hdr_cnt_q == 3'(HDR_LEN_LO)) begin
                            data_cnt_q <= tgt_req_bits;
                        end
                        if (hdr_cnt_q == 3'(HDR_WORDS - 1)) begin
                            hdr_cnt_q <= '0;
                            case (cmd_q)
                                TSI_CMD_READ:  state_q <= RDATA;
                                TSI_CMD_WRITE: state_q <= WDATA;
                                default:       state_q <= IDLE;
                            endcase
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        end
                    end
                end
                WDATA: begin
                    if (req_xfer) begin
                        if (data_cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            data_cnt_q <= data_cnt_q - 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (resp_xfer) begin
                        if (data_cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            data_cnt_q <= data_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q != IDLE);
    assign err   = err_q;

endmodule

// File: tb/tb_tsi_link_arbiter.sv
// Randomised scoreboard bench for tsi_link_arbiter with a packet-level reference model.
module tb_tsi_link_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      host_req_valid, host_req_ready;
    logic [NREQ*32-1:0]   host_req_bits, host_resp_bits;
    logic [NREQ-1:0]      host_resp_valid, host_resp_ready;
    logic                 tgt_req_valid, tgt_req_ready, tgt_resp_valid, tgt_resp_ready;
    logic [31:0]          tgt_req_bits, tgt_resp_bits;
    logic [IDW-1:0]       owner;
    logic                 busy, err;

    always #5 clock = ~clock;

    tsi_link_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clock           (clock),
        .reset           (reset),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_bits   (host_req_bits),
        .host_resp_valid (host_resp_valid),
        .host_resp_ready (host_resp_ready),
        .host_resp_bits  (host_resp_bits),
        .tgt_req_valid   (tgt_req_valid),
        .tgt_req_ready   (tgt_req_ready),
        .tgt_req_bits    (tgt_req_bits),
        .tgt_resp_valid  (tgt_resp_valid),
        .tgt_resp_ready  (tgt_resp_ready),
        .tgt_resp_bits   (tgt_resp_bits),
        .owner           (owner),
        .busy            (busy),
        .err             (err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs (percent probabilities)
    int unsigned rdy_pct = 100, gap_pct = 0, hrr_pct = 100, rsp_pct = 50;

    logic [31:0] tx_q      [NREQ][$];
    bit          tx_first  [NREQ][$];
    logic [31:0] exp_words [NREQ][$];
    logic [31:0] resp_sb   [$];
    int          own_log   [$];

    // Packet-level reference model
    bit          m_busy;
    int unsigned m_owner, m_ptr, m_pos;
    longint      m_req_words, m_resp_left;
    logic [31:0] m_cmd, m_len;
    bit          m_err;
    int          rd_cnt [NREQ];
    int          nxfer = 0;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = NREQ - 1; m_pos = 0;
        m_req_words = 5; m_resp_left = 0; m_err = 0;
    endtask

    task automatic send_pkt(input int unsigned r, input logic [31:0] cmd, input logic [31:0] addr,
                            input logic [31:0] len, input logic [31:0] len_hi, input int unsigned ndata,
                            input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] w [$];
        w.push_back(cmd); w.push_back(addr); w.push_back(32'h0);
        w.push_back(len); w.push_back(len_hi);
        for (int unsigned i = 0; i < ndata; i++)
            w.push_back(i == 0 ? d0 : (i == 1 ? d1 : $urandom));
        foreach (w[k]) begin
            tx_q[r].push_back(w[k]);
            tx_first[r].push_back(k == 0);
            exp_words[r].push_back(w[k]);
        end
    endtask

    // Requester and target drivers: decide on negedge, update just after posedge
    initial begin : drive
        bit acc [NREQ];
        bit racc;
        host_req_valid = '0; host_req_bits = '0; tgt_req_ready = 1'b0;
        host_resp_ready = '0; tgt_resp_valid = 1'b0; tgt_resp_bits = '0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) acc[i] = host_req_valid[i] && host_req_ready[i];
            racc = tgt_resp_valid && tgt_resp_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && tx_q[i].size() > 0) begin
                    void'(tx_q[i].pop_front());
                    void'(tx_first[i].pop_front());
                end
                if (tx_q[i].size() > 0) begin
                    host_req_bits[i*32 +: 32] = tx_q[i][0];
                    host_req_valid[i] = tx_first[i][0] || ($urandom_range(99) >= gap_pct);
                end else begin
                    host_req_valid[i] = 1'b0;
                end
                host_resp_ready[i] = ($urandom_range(99) < hrr_pct);
            end
            tgt_req_ready = ($urandom_range(99) < rdy_pct);
            if (racc) tgt_resp_valid = 1'b0;
            if (!tgt_resp_valid && !reset && $urandom_range(99) < rsp_pct) begin
                tgt_resp_valid = 1'b1;
                tgt_resp_bits  = $urandom;
                resp_sb.push_back(tgt_resp_bits);
            end
        end
    end

    // Monitor: compares DUT outputs with the model, then advances the model for the coming edge
    initial begin : monitor
        bit             req_ph, rsp_ph, found;
        logic [NREQ-1:0] ev;
        logic [IDW-1:0] mo;
        logic [31:0]    w, r;
        int unsigned    c;
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset) begin
                mo     = IDW'(m_owner);
                req_ph = m_busy && (longint'(m_pos) < m_req_words);
                rsp_ph = m_busy && !req_ph && (m_resp_left > 0);
                chk("busy", busy, m_busy);
                chk("owner", owner, mo);
                chk("err", err, m_err);
                chk("tgt_req_valid", tgt_req_valid, req_ph ? host_req_valid[mo] : 1'b0);
                ev = '0; if (req_ph) ev[mo] = tgt_req_ready;
                chk("host_req_ready", host_req_ready, ev);
                chk("tgt_resp_ready", tgt_resp_ready, rsp_ph ? host_resp_ready[mo] : 1'b0);
                ev = '0; if (rsp_ph) ev[mo] = tgt_resp_valid;
                chk("host_resp_valid", host_resp_valid, ev);
                if (!m_busy) begin
                    found = 0;
                    for (int unsigned k = 1; k <= NREQ; k++) begin
                        c = (m_ptr + k) % NREQ;
                        if (!found && host_req_valid[c]) begin
                            found = 1; m_owner = c;
                        end
                    end
                    if (found) begin
                        m_ptr = m_owner; m_busy = 1; m_pos = 0;
                        m_req_words = 5; m_resp_left = 0;
                    end
                end else if (req_ph) begin
                    if (host_req_valid[mo] && tgt_req_ready) begin
                        if (exp_words[m_owner].size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_word: actual=%0h required=none", tgt_req_bits);
                            w = tgt_req_bits;
                        end else begin
                            w = exp_words[m_owner].pop_front();
                            chk("tgt_req_bits", tgt_req_bits, w);
                        end
                        if (m_pos == 0) begin
                            m_cmd = w;
                            own_log.push_back(int'(owner));
                            if (w > 1) m_err = 1;
                        end
                        if (m_pos == 3) m_len = w;
                        m_pos++;
                        nxfer++;
                        if (m_pos == 5) begin
                            if (m_cmd == 1) m_req_words = 5 + longint'(m_len) + 1;
                            else if (m_cmd == 0) m_resp_left = longint'(m_len) + 1;
                        end
                        if (longint'(m_pos) == m_req_words && m_resp_left == 0) m_busy = 0;
                    end
                end else if (rsp_ph) begin
                    if (tgt_resp_valid && host_resp_ready[mo]) begin
                        if (resp_sb.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_resp: actual=%0h required=none", host_resp_bits);
                        end else begin
                            r = resp_sb.pop_front();
                            chk("host_resp_bits", host_resp_bits, {NREQ{r}});
                        end
                        rd_cnt[m_owner]++;
                        m_resp_left--;
                        if (m_resp_left == 0) m_busy = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge clock);
            if (!m_busy && tx_q[0].size() == 0 && tx_q[1].size() == 0) begin
                repeat (2) @(negedge clock);
                return;
            end
        end
        tests++; fails++;
        $display("FAIL %s_timeout: actual=busy required=idle within %0d cycles", name, max_cycles);
    endtask

    task automatic assert_reset();
        @(posedge clock);
        #3;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tx_q[i].delete(); tx_first[i].delete(); exp_words[i].delete();
        end
        resp_sb.delete();
        own_log.delete();
        tgt_resp_valid = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    initial begin : stim
        int base, rd0, rd1;
        int exp_rd [NREQ];
        logic [31:0] cmd, len;
        int unsigned r, sel;

        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_tgt_req_valid", tgt_req_valid, 1'b0);
        chk("rst_tgt_resp_ready", tgt_resp_ready, 1'b0);
        chk("rst_host_req_ready", host_req_ready, '0);
        chk("rst_host_resp_valid", host_resp_valid, '0);
        repeat (2) @(posedge clock);
        release_reset();

        // Single-requester write
        base = nxfer; rd0 = rd_cnt[0]; rd1 = rd_cnt[1];
        send_pkt(0, 32'd1, 32'h8000_0000, 32'd1, 32'd0, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_idle("t1", 200);
        chk("t1_words", 64'(nxfer - base), 64'd7);
        chk("t1_no_resp", 64'(rd_cnt[0] + rd_cnt[1] - rd0 - rd1), 64'd0);

        // Read with response backpressure
        hrr_pct = 50;
        rd0 = rd_cnt[0]; rd1 = rd_cnt[1];
        send_pkt(1, 32'd0, 32'h1000, 32'd2, 32'd0, 0, 32'd0, 32'd0);
        wait_idle("t2", 500);
        chk("t2_resp_req1", 64'(rd_cnt[1] - rd1), 64'd3);
        chk("t2_resp_req0", 64'(rd_cnt[0] - rd0), 64'd0);

        // Contention from reset: grants alternate
        hrr_pct = 100;
        assert_reset();
        for (int k = 0; k < 2; k++) begin
            send_pkt(0, 32'd1, 32'h100, 32'd0, 32'd0, 1, 32'h0A0A_0000, 32'd0);
            send_pkt(1, 32'd1, 32'h200, 32'd0, 32'd0, 1, 32'h0B0B_0000, 32'd0);
        end
        release_reset();
        wait_idle("t3", 500);
        chk("t3_grants", 64'(own_log.size()), 64'd4);
        if (own_log.size() == 4) begin
            chk("t3_grant0", 64'(own_log[0]), 64'd0);
            chk("t3_grant1", 64'(own_log[1]), 64'd1);
            chk("t3_grant2", 64'(own_log[2]), 64'd0);
            chk("t3_grant3", 64'(own_log[3]), 64'd1);
        end

        // Illegal command, then a legal packet
        base = nxfer;
        send_pkt(0, 32'd7, 32'h300, 32'd4, 32'd0, 0, 32'd0, 32'd0);
        wait_idle("t4a", 200);
        chk("t4_err_set", err, 1'b1);
        chk("t4_hdr_words", 64'(nxfer - base), 64'd5);
        send_pkt(1, 32'd1, 32'h400, 32'd0, 32'd0, 1, 32'h1234_5678, 32'd0);
        wait_idle("t4b", 200);
        chk("t4_err_sticky", err, 1'b1);

        // Reset in the middle of a 2^32-beat write
        base = nxfer;
        send_pkt(0, 32'd1, 32'h500, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 32'h1, 32'h2);
        for (int n = 0; n < 300 && (nxfer - base) < 8; n++) @(negedge clock);
        chk("t5_reached_wdata", 64'(nxfer - base), 64'd8);
        assert_reset();
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_tgt_req_valid", tgt_req_valid, 1'b0);
        chk("t5_host_req_ready", host_req_ready, '0);
        chk("t5_owner", owner, '0);
        chk("t5_err", err, 1'b0);
        repeat (2) @(posedge clock);
        release_reset();
        send_pkt(0, 32'd1, 32'h600, 32'd1, 32'd0, 2, 32'h55, 32'h66);
        wait_idle("t5", 200);
        chk("t5_new_pkt", 64'(own_log.size()), 64'd1);
        if (own_log.size() == 1) chk("t5_new_owner", 64'(own_log[0]), 64'd0);

        // Single-beat read; a further response must stay stalled
        rsp_pct = 100;
        rd0 = rd_cnt[0];
        send_pkt(0, 32'd0, 32'h700, 32'd0, 32'd0, 0, 32'd0, 32'd0);
        wait_idle("t6", 200);
        chk("t6_one_resp", 64'(rd_cnt[0] - rd0), 64'd1);
        repeat (5) @(negedge clock);
        chk("t6_stall_ready", tgt_resp_ready, 1'b0);
        chk("t6_stall_valid", host_resp_valid, '0);

        // Randomised traffic with backpressure and mid-packet valid gaps
        rdy_pct = 70; gap_pct = 20; hrr_pct = 60; rsp_pct = 50;
        for (int i = 0; i < NREQ; i++) exp_rd[i] = rd_cnt[i];
        for (int p = 0; p < 40; p++) begin
            r   = $urandom_range(NREQ - 1);
            sel = $urandom_range(9);
            cmd = (sel < 4) ? 32'd0 : ((sel < 9) ? 32'd1 : 32'd5);
            len = 32'($urandom_range(3));
            send_pkt(r, cmd, $urandom, len, $urandom, (cmd == 1) ? int'(len) + 1 : 0, $urandom, $urandom);
            if (cmd == 0) exp_rd[r] += int'(len) + 1;
        end
        wait_idle("t7", 20000);
        chk("t7_resp_req0", 64'(rd_cnt[0]), 64'(exp_rd[0]));
        chk("t7_resp_req1", 64'(rd_cnt[1]), 64'(exp_rd[1]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #900000;
        fails++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
